// File: rtl/puf_response_buffer.sv
// puf_response_buffer: synchronises the asynchronous race-arbiter outputs,
// assembles RESP_BITS race bits into a response word (first bit ends in the
// MSB), hands it to the host with a ready/ack handshake, and sequences the
// local arbiter/scrambler/counter resets between races.
//
// Optional feature: define RACE_TIMEOUT_EN to add a watchdog that flags a
// stalled race after TIMEOUT_CYCLES cycles in COLLECT and kicks a local
// reset sequence. Without it timeout_flag is tied low.
//
// state   | meaning
// COLLECT | shifting in race bits, response not yet complete
// FULL    | response complete, waiting for read_ack; new bits are dropped
module puf_response_buffer #(
    parameter int RESP_BITS      = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int RESET_DELAY    = 2,
    parameter int RESET_WIDTH    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             data_in,
    input  logic                             bit_done,
    input  logic                             read_ack,
    output logic [RESP_BITS-1:0]             data_out,
    output logic [$clog2(RESP_BITS+1)-1:0]   count,
    output logic                             ready_to_read,
    output logic                             full,
    output logic                             empty,
    output logic                             overrun,
    output logic                             timeout_flag,
    output logic                             arbiter_reset,
    output logic                             scrambler_reset,
    output logic                             counter_reset
);
    localparam int CW = $clog2(RESP_BITS + 1);
    localparam int SW = 5;
    localparam logic [CW-1:0] CNT_LAST  = CW'(RESP_BITS - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(RESP_BITS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [SW-1:0] SEQ_LOAD  = SW'(RESET_DELAY + RESET_WIDTH - 1);
    localparam logic [SW-1:0] SEQ_WIDTH = SW'(RESET_WIDTH);
    localparam logic [SW-1:0] SEQ_ONE   = SW'(1);

    if (RESP_BITS < 2 || RESP_BITS > 64 || SYNC_STAGES < 2 || SYNC_STAGES > 6 ||
        RESET_DELAY < 1 || RESET_DELAY > 15 || RESET_WIDTH < 1 || RESET_WIDTH > 15 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("puf_response_buffer: parameter out of legal range");
    end

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] done_sync, data_sync;
    logic                   done_prev, capture, cap_bit;
    logic [RESP_BITS-1:0]   data_nxt;
    logic [CW-1:0]          count_nxt;
    logic                   ready_nxt, overrun_nxt, launch;
    logic [SW-1:0]          seq_rem, seq_nxt;
    logic                   arb_q, arb_nxt, cnt_q;

`ifdef RACE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    logic [WD_W-1:0] wd, wd_nxt;
    logic            timeout_nxt;
`endif

    // Synchronise the arbiter outputs and register a one-cycle capture pulse on bit_done falling.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_sync <= '0;
            data_sync <= '0;
            done_prev <= 1'b0;
            capture   <= 1'b0;
            cap_bit   <= 1'b0;
        end else begin
            done_sync <= {done_sync[SYNC_STAGES-2:0], bit_done};
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
            done_prev <= done_sync[SYNC_STAGES-1];
            capture   <= done_prev & ~done_sync[SYNC_STAGES-1];
            cap_bit   <= data_sync[SYNC_STAGES-1];
        end
    end

    // State, response and reset-sequencer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= COLLECT;
            data_out      <= '0;
            count         <= '0;
            ready_to_read <= 1'b0;
            overrun       <= 1'b0;
            seq_rem       <= '0;
            arb_q         <= 1'b0;
            cnt_q         <= 1'b0;
        end else begin
            state         <= state_nxt;
            data_out      <= data_nxt;
            count         <= count_nxt;
            ready_to_read <= ready_nxt;
            overrun       <= overrun_nxt;
            seq_rem       <= seq_nxt;
            arb_q         <= arb_nxt;
            cnt_q         <= arb_q;
        end
    end

`ifdef RACE_TIMEOUT_EN
    // Watchdog down-counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd           <= WD_LOAD;
            timeout_flag <= 1'b0;
        end else begin
            wd           <= wd_nxt;
            timeout_flag <= timeout_nxt;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

    // Next-state, response update and reset-sequence launch.
    always_comb begin
        state_nxt   = state;
        data_nxt    = data_out;
        count_nxt   = count;
        ready_nxt   = ready_to_read;
        overrun_nxt = overrun;
        launch      = capture;
`ifdef RACE_TIMEOUT_EN
        wd_nxt      = wd;
        timeout_nxt = timeout_flag;
`endif
        case (state)
            COLLECT: begin
                if (capture) begin
                    data_nxt  = {data_out[RESP_BITS-2:0], cap_bit};
                    count_nxt = count + CNT_ONE;
                    if (count == CNT_LAST) begin
                        state_nxt = FULL;
                        ready_nxt = 1'b1;
                    end
                end
`ifdef RACE_TIMEOUT_EN
                if (capture) begin
                    wd_nxt = WD_LOAD;
                end else if (wd <= WD_ONE) begin
                    wd_nxt      = WD_LOAD;
                    timeout_nxt = 1'b1;
                    launch      = 1'b1;
                end else begin
                    wd_nxt = wd - WD_ONE;
                end
`endif
            end
            FULL: begin
                if (read_ack) begin
                    // A bit captured on the ack edge starts the next response.
                    state_nxt   = COLLECT;
                    ready_nxt   = 1'b0;
                    overrun_nxt = 1'b0;
                    launch      = 1'b1;
                    data_nxt    = {{(RESP_BITS-1){1'b0}}, capture & cap_bit};
                    count_nxt   = capture ? CNT_ONE : '0;
`ifdef RACE_TIMEOUT_EN
                    timeout_nxt = 1'b0;
                    wd_nxt      = WD_LOAD;
`endif
                end else if (capture) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: state_nxt = COLLECT;
        endcase

        // Remaining cycles to the end of the pulse; pulse is high for the last RESET_WIDTH values.
        if (launch) begin
            seq_nxt = SEQ_LOAD;
        end else if (seq_rem != '0) begin
            seq_nxt = seq_rem - SEQ_ONE;
        end else begin
            seq_nxt = '0;
        end
        arb_nxt = (seq_nxt != '0) && (seq_nxt <= SEQ_WIDTH);
    end

    assign full            = (count == CNT_FULL);
    assign empty           = (count == '0);
    assign arbiter_reset   = arb_q | ~reset_n;
    assign scrambler_reset = arb_q | ~reset_n;
    assign counter_reset   = cnt_q | ~reset_n;

endmodule
